fmac_share_ctrl: RTL and testbench

Sequencer and arbiter that time-shares one fmac instance (Result = a + b*c, single precision) between NUM_REQ requesters.
- Round-robin grant; the winner's operands and rounding mode are registered and held stable on the fmac inputs for LATENCY cycles.
- The fmac result and flags are captured into a result register and returned through a valid/ready handshake tagged with the requester ID.
- Accumulates sticky exception flags. Sits between issue logic (core/cluster ports) and the fmac datapath.

---
 rtl/fmac_share_ctrl_pkg.sv | 23 ++
 rtl/fmac_share_ctrl_rr_arbiter.sv | 33 +++
 rtl/fmac_share_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fmac_share_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmac_share_ctrl_pkg.sv
// Shared definitions for the time-shared fmac controller: FSM states, flag
// bit positions, field widths and the round-robin pointer helper.
package fmac_share_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } fmac_share_state_e;

    localparam int unsigned C_FLAG_OF = 2;
    localparam int unsigned C_FLAG_UF = 1;
    localparam int unsigned C_FLAG_NX = 0;
    localparam int unsigned C_FLAGS_W = 3;

    localparam int unsigned C_FMAC_RM = 3;
    localparam int unsigned C_CNT_W   = 4;

    function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
        return (w + 1 == n) ? 0 : w + 1;
    endfunction

endpackage

// File: rtl/fmac_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above the
// pointer, wrapping around; one-hot grant plus encoded winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_o
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr_i) + off) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                gnt_o[idx]    = 1'b1;
                winner_o      = ID_W'(idx);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fmac_share_ctrl.sv
// Time-shares one fmac between NUM_REQ requesters: round-robin issue, held
// operands for LATENCY cycles, tagged result handshake and sticky flags.
module fmac_share_ctrl
    import fmac_share_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned LATENCY = 1,
    localparam int unsigned C_ID_W  = $clog2(NUM_REQ)
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_RBI,
    input  logic                        Flush_SI,
    input  logic [NUM_REQ-1:0]          Req_Valid_SI,
    output logic [NUM_REQ-1:0]          Req_Ready_SO,
    input  logic [NUM_REQ*32-1:0]       Req_Op_a_DI,
    input  logic [NUM_REQ*32-1:0]       Req_Op_b_DI,
    input  logic [NUM_REQ*32-1:0]       Req_Op_c_DI,
    input  logic [NUM_REQ*C_FMAC_RM-1:0] Req_RM_DI,
    output logic [31:0]                 Fmac_Op_a_DO,
    output logic [31:0]                 Fmac_Op_b_DO,
    output logic [31:0]                 Fmac_Op_c_DO,
    output logic [C_FMAC_RM-1:0]        Fmac_RM_SO,
    input  logic [31:0]                 Fmac_Result_DI,
    input  logic                        Fmac_OF_SI,
    input  logic                        Fmac_UF_SI,
    input  logic                        Fmac_NX_SI,
    output logic                        Res_Valid_SO,
    input  logic                        Res_Ready_SI,
    output logic [31:0]                 Res_Result_DO,
    output logic [C_ID_W-1:0]           Res_Id_DO,
    output logic [C_FLAGS_W-1:0]        Res_Flags_DO,
    output logic [C_FLAGS_W-1:0]        Fflags_DO,
    input  logic                        Fflags_Clr_SI
);

    fmac_share_state_e    state_q, state_d;
    logic [C_ID_W-1:0]    ptr_q, ptr_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]          op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [C_FMAC_RM-1:0] rm_q, rm_d;
    logic [C_ID_W-1:0]    id_q, id_d;
    logic [31:0]          res_q, res_d;
    logic [C_FLAGS_W-1:0] res_flags_q, res_flags_d;
    logic [C_FLAGS_W-1:0] fflags_q, fflags_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [C_ID_W-1:0]    winner;
    logic                 any_req;
    logic                 arb_en, accept, handshake;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (C_ID_W)
    ) i_arb (
        .req_i    (Req_Valid_SI),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .winner_o (winner),
        .any_o    (any_req)
    );

    // Grant window: idle, or a result leaving this cycle; never during flush or reset.
    assign arb_en    = Rst_RBI && !Flush_SI &&
                       (state_q == IDLE || (state_q == DONE && Res_Ready_SI));
    assign accept    = arb_en && any_req;
    assign handshake = !Flush_SI && state_q == DONE && Res_Ready_SI;

    assign Req_Ready_SO  = arb_en ? gnt : '0;
    assign Fmac_Op_a_DO  = op_a_q;
    assign Fmac_Op_b_DO  = op_b_q;
    assign Fmac_Op_c_DO  = op_c_q;
    assign Fmac_RM_SO    = rm_q;
    assign Res_Valid_SO  = (state_q == DONE);
    assign Res_Result_DO = res_q;
    assign Res_Id_DO     = id_q;
    assign Res_Flags_DO  = res_flags_q;
    assign Fflags_DO     = fflags_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        rm_d        = rm_q;
        id_d        = id_q;
        res_d       = res_q;
        res_flags_d = res_flags_q;
        fflags_d    = fflags_q;

        if (Flush_SI) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        res_d                  = Fmac_Result_DI;
                        res_flags_d[C_FLAG_OF] = Fmac_OF_SI;
                        res_flags_d[C_FLAG_UF] = Fmac_UF_SI;
                        res_flags_d[C_FLAG_NX] = Fmac_NX_SI;
                        state_d                = DONE;
                    end
                end
                DONE: if (Res_Ready_SI) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            // Accept only happens from IDLE/DONE, so it overrides the plain transition.
            if (accept) begin
                op_a_d  = Req_Op_a_DI[32*winner +: 32];
                op_b_d  = Req_Op_b_DI[32*winner +: 32];
                op_c_d  = Req_Op_c_DI[32*winner +: 32];
                rm_d    = Req_RM_DI[C_FMAC_RM*winner +: C_FMAC_RM];
                id_d    = winner;
                cnt_d   = C_CNT_W'(LATENCY - 1);
                ptr_d   = C_ID_W'(rr_next(int'(winner), NUM_REQ));
                state_d = EXEC;
            end

            if (handshake) begin
                fflags_d = (Fflags_Clr_SI ? '0 : fflags_q) | res_flags_q;
            end else if (Fflags_Clr_SI) begin
                fflags_d = '0;
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            rm_q        <= '0;
            id_q        <= '0;
            res_q       <= '0;
            res_flags_q <= '0;
            fflags_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            rm_q        <= rm_d;
            id_q        <= id_d;
            res_q       <= res_d;
            res_flags_q <= res_flags_d;
            fflags_q    <= fflags_d;
        end
    end

endmodule

// File: tb/tb_fmac_share_ctrl.sv
// Self-checking bench for fmac_share_ctrl with a behavioural fmac stand-in.
module tb_fmac_share_ctrl;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, res_ready, fclr;
    logic [N-1:0]  valid;
    logic [31:0]   op_a [N];
    logic [31:0]   op_b [N];
    logic [31:0]   op_c [N];
    logic [2:0]    rm   [N];
    logic [N*32-1:0] bus_a, bus_b, bus_c;
    logic [N*3-1:0]  bus_rm;

    always_comb begin
        bus_a  = '0;
        bus_b  = '0;
        bus_c  = '0;
        bus_rm = '0;
        for (int i = 0; i < N; i++) begin
            bus_a[32*i +: 32] = op_a[i];
            bus_b[32*i +: 32] = op_b[i];
            bus_c[32*i +: 32] = op_c[i];
            bus_rm[3*i +: 3]  = rm[i];
        end
    end

    // Stand-in fmac: two exact IEEE cases from the plan, otherwise a deterministic scramble.
    function automatic logic [34:0] fmac_model(input logic [31:0] a, b, c, input logic [2:0] r);
        if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000)
            return {3'b000, 32'h40E00000};
        if (a == 32'h0 && b == 32'h7F7FFFFF && c == 32'h40000000)
            return {3'b101, 32'h7F800000};
        return {a[2:0] ^ b[2:0] ^ c[2:0], a ^ {b[15:0], c[31:16]} ^ {29'd0, r}};
    endfunction

    logic [N-1:0] d1_ready, d2_ready;
    logic [31:0]  d1_fa, d1_fb, d1_fc, d2_fa, d2_fb, d2_fc;
    logic [2:0]   d1_frm, d2_frm;
    logic [31:0]  d1_fres, d2_fres;
    logic         d1_of, d1_uf, d1_nx, d2_of, d2_uf, d2_nx;
    logic         d1_rv, d2_rv;
    logic [31:0]  d1_res, d2_res;
    logic [1:0]   d1_id, d2_id;
    logic [2:0]   d1_rfl, d2_rfl, d1_ff, d2_ff;

    always_comb {d1_of, d1_uf, d1_nx, d1_fres} = fmac_model(d1_fa, d1_fb, d1_fc, d1_frm);
    always_comb {d2_of, d2_uf, d2_nx, d2_fres} = fmac_model(d2_fa, d2_fb, d2_fc, d2_frm);

    fmac_share_ctrl #(.NUM_REQ(N), .LATENCY(1)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Flush_SI(flush),
        .Req_Valid_SI(valid), .Req_Ready_SO(d1_ready),
        .Req_Op_a_DI(bus_a), .Req_Op_b_DI(bus_b), .Req_Op_c_DI(bus_c), .Req_RM_DI(bus_rm),
        .Fmac_Op_a_DO(d1_fa), .Fmac_Op_b_DO(d1_fb), .Fmac_Op_c_DO(d1_fc), .Fmac_RM_SO(d1_frm),
        .Fmac_Result_DI(d1_fres), .Fmac_OF_SI(d1_of), .Fmac_UF_SI(d1_uf), .Fmac_NX_SI(d1_nx),
        .Res_Valid_SO(d1_rv), .Res_Ready_SI(res_ready), .Res_Result_DO(d1_res),
        .Res_Id_DO(d1_id), .Res_Flags_DO(d1_rfl), .Fflags_DO(d1_ff), .Fflags_Clr_SI(fclr)
    );

    fmac_share_ctrl #(.NUM_REQ(N), .LATENCY(4)) dut_l4 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Flush_SI(flush),
        .Req_Valid_SI(valid), .Req_Ready_SO(d2_ready),
        .Req_Op_a_DI(bus_a), .Req_Op_b_DI(bus_b), .Req_Op_c_DI(bus_c), .Req_RM_DI(bus_rm),
        .Fmac_Op_a_DO(d2_fa), .Fmac_Op_b_DO(d2_fb), .Fmac_Op_c_DO(d2_fc), .Fmac_RM_SO(d2_frm),
        .Fmac_Result_DI(d2_fres), .Fmac_OF_SI(d2_of), .Fmac_UF_SI(d2_uf), .Fmac_NX_SI(d2_nx),
        .Res_Valid_SO(d2_rv), .Res_Ready_SI(res_ready), .Res_Result_DO(d2_res),
        .Res_Id_DO(d2_id), .Res_Flags_DO(d2_rfl), .Fflags_DO(d2_ff), .Fflags_Clr_SI(fclr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        res_ready = 1'b0;
        fclr      = 1'b0;
        valid     = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_c[i] = '0; rm[i] = '0;
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Issues one op on the LATENCY=1 instance from IDLE and leaves it in DONE.
    task automatic run_op(input int r, input logic [31:0] a, b, c, input logic [2:0] m);
        valid   = '0;
        valid[r] = 1'b1;
        op_a[r] = a; op_b[r] = b; op_c[r] = c; rm[r] = m;
        settle();
        chk("issue_grant", 32'(d1_ready), 32'(1) << r);
        step();
        valid = '0;
        settle();
        chk("exec_no_valid", 32'(d1_rv), 32'd1 - 32'd1 + 32'(1'b0));
        chk("exec_op_a", d1_fa, a);
        step();
        settle();
        chk("done_valid", 32'(d1_rv), 32'd1);
        chk("done_id", 32'(d1_id), 32'(r));
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        settle();
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic         rr;
        logic [N-1:0] exp_ready;
        logic         exp_rv;
        logic [1:0]   exp_id;
    } vec_t;

    vec_t tbl [12];

    // Transaction-level reference for the random phase.
    int          cyc, m_ptr, m_ready_at, m_id, w;
    bit          m_inflight, m_hold, m_can;
    logic [31:0] m_res, m_opa;
    logic [2:0]  m_fl, m_ff;
    logic [34:0] m_out;
    logic [31:0] ovf_res;

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        // Reset values and continuous round-robin.
        do_reset();
        settle();
        chk("reset_valid", 32'(d1_rv), 32'd0);
        chk("reset_ff", 32'(d1_ff), 32'd0);
        chk("reset_op_a", d1_fa, 32'd0);
        chk("reset_result", d1_res, 32'd0);
        for (int i = 0; i < 12; i++) begin
            valid     = tbl[i].valid;
            res_ready = tbl[i].rr;
            settle();
            chk($sformatf("rr_ready[%0d]", i), 32'(d1_ready), 32'(tbl[i].exp_ready));
            chk($sformatf("rr_valid[%0d]", i), 32'(d1_rv), 32'(tbl[i].exp_rv));
            chk($sformatf("rr_id[%0d]", i), 32'(d1_id), 32'(tbl[i].exp_id));
            step();
        end
        res_ready = 1'b0;
        valid     = '0;

        // Single op, overflow flags and sticky behaviour.
        do_reset();
        run_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
        chk("t1_result", d1_res, 32'h40E00000);
        chk("t1_flags", 32'(d1_rfl), 32'd0);
        handshake();
        chk("t1_drop", 32'(d1_rv), 32'd0);

        run_op(1, 32'h0, 32'h7F7FFFFF, 32'h40000000, 3'b000);
        chk("t3_result", d1_res, 32'h7F800000);
        chk("t3_flags", 32'(d1_rfl), 32'b101);
        chk("t3_ff_pre", 32'(d1_ff), 32'd0);
        handshake();
        chk("t3_ff_set", 32'(d1_ff), 32'b101);
        run_op(2, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
        chk("t3_exact_flags", 32'(d1_rfl), 32'd0);
        handshake();
        chk("t3_ff_keep", 32'(d1_ff), 32'b101);
        fclr = 1'b1;
        step();
        fclr = 1'b0;
        settle();
        chk("t3_ff_clr", 32'(d1_ff), 32'd0);

        // Back-pressure in DONE, then handshake with same-cycle accept.
        run_op(3, 32'h11111111, 32'h22222222, 32'h33333333, 3'd2);
        m_out = fmac_model(32'h11111111, 32'h22222222, 32'h33333333, 3'd2);
        valid = 4'b0100;
        op_a[2] = 32'h44444444; op_b[2] = 32'h55555555; op_c[2] = 32'h66666666; rm[2] = 3'd1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t4_hold_valid", 32'(d1_rv), 32'd1);
            chk("t4_hold_result", d1_res, m_out[31:0]);
            chk("t4_hold_id", 32'(d1_id), 32'd3);
            chk("t4_hold_ready", 32'(d1_ready), 32'd0);
            step();
        end
        res_ready = 1'b1;
        settle();
        chk("t4_b2b_ready", 32'(d1_ready), 32'b0100);
        step();
        res_ready = 1'b0;
        valid     = '0;
        settle();
        chk("t4_b2b_exec", 32'(d1_rv), 32'd0);
        chk("t4_b2b_op_a", d1_fa, 32'h44444444);
        step();
        settle();
        m_out = fmac_model(32'h44444444, 32'h55555555, 32'h66666666, 3'd1);
        chk("t4_b2b_valid", 32'(d1_rv), 32'd1);
        chk("t4_b2b_id", 32'(d1_id), 32'd2);
        chk("t4_b2b_result", d1_res, m_out[31:0]);
        handshake();

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_ptr = 0; m_inflight = 0; m_ready_at = 0; m_id = 0;
        m_res = '0; m_fl = '0; m_ff = '0; m_opa = '0;
        for (cyc = 0; cyc < 400; cyc++) begin
            valid     = N'($urandom_range(0, 15));
            res_ready = ($urandom % 3) != 0;
            fclr      = ($urandom % 10) == 0;
            for (int i = 0; i < N; i++) begin
                op_a[i] = $urandom; op_b[i] = $urandom; op_c[i] = $urandom;
                rm[i] = 3'($urandom_range(0, 4));
            end
            settle();
            m_hold = m_inflight && cyc >= m_ready_at;
            m_can  = !m_inflight || (m_hold && res_ready);
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            chk("rnd_ready", 32'(d1_ready), (m_can && w >= 0) ? (32'(1) << w) : 32'd0);
            chk("rnd_valid", 32'(d1_rv), 32'(m_hold));
            chk("rnd_ff", 32'(d1_ff), 32'(m_ff));
            if (m_inflight) chk("rnd_op_a_held", d1_fa, m_opa);
            if (m_hold) begin
                chk("rnd_result", d1_res, m_res);
                chk("rnd_id", 32'(d1_id), 32'(m_id));
                chk("rnd_flags", 32'(d1_rfl), 32'(m_fl));
            end
            if (m_hold && res_ready) begin
                m_ff = (fclr ? 3'b000 : m_ff) | m_fl;
                m_inflight = 0;
            end else if (fclr) begin
                m_ff = '0;
            end
            if (m_can && w >= 0) begin
                m_out      = fmac_model(op_a[w], op_b[w], op_c[w], rm[w]);
                m_res      = m_out[31:0];
                m_fl       = m_out[34:32];
                m_opa      = op_a[w];
                m_id       = w;
                m_inflight = 1;
                m_ready_at = cyc + 2;
                m_ptr      = (w + 1) % N;
            end
            step();
        end
        valid = '0; res_ready = 1'b0; fclr = 1'b0;

        // LATENCY=4 instance: exact latency, then flush mid-EXEC.
        do_reset();
        valid = 4'b0001;
        op_a[0] = 32'h0; op_b[0] = 32'h7F7FFFFF; op_c[0] = 32'h40000000; rm[0] = 3'd0;
        settle();
        chk("t5_grant0", 32'(d2_ready), 32'b0001);
        step();
        valid = '0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t5_exec_no_valid", 32'(d2_rv), 32'd0);
            step();
        end
        settle();
        chk("t5_valid", 32'(d2_rv), 32'd1);
        chk("t5_result", d2_res, 32'h7F800000);
        handshake();
        chk("t5_ff", 32'(d2_ff), 32'b101);
        valid = 4'b0010;
        op_a[1] = 32'h12345678; op_b[1] = 32'h9ABCDEF0; op_c[1] = 32'h0F0F0F0F;
        settle();
        chk("t5_grant1", 32'(d2_ready), 32'b0010);
        step();
        valid = '0;
        step();
        flush = 1'b1;
        valid = 4'b1111;
        settle();
        chk("t5_flush_ready", 32'(d2_ready), 32'd0);
        step();
        flush = 1'b0;
        valid = '0;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("t5_post_flush_valid", 32'(d2_rv), 32'd0);
            chk("t5_post_flush_ff", 32'(d2_ff), 32'b101);
            step();
        end
        valid = 4'b1111;
        settle();
        chk("t5_ptr_kept", 32'(d2_ready), 32'b0100);
        valid = '0;
        step();

        // Asynchronous reset in the middle of EXEC.
        do_reset();
        run_op(0, 32'h0, 32'h7F7FFFFF, 32'h40000000, 3'b000);
        valid = 4'b0010;
        op_a[1] = 32'hCAFEF00D; op_b[1] = 32'hDEADBEEF; op_c[1] = 32'h01234567; rm[1] = 3'd3;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        valid = 4'b0001;
        settle();
        chk("t6_pre_ff", 32'(d1_ff), 32'b101);
        chk("t6_pre_op_a", d1_fa, 32'hCAFEF00D);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(d1_rv), 32'd0);
        chk("t6_rst_ready", 32'(d1_ready), 32'd0);
        chk("t6_rst_op_a", d1_fa, 32'd0);
        chk("t6_rst_rm", 32'(d1_frm), 32'd0);
        chk("t6_rst_result", d1_res, 32'd0);
        chk("t6_rst_flags", 32'(d1_rfl), 32'd0);
        chk("t6_rst_ff", 32'(d1_ff), 32'd0);
        #1 rst_n = 1'b1;
        valid = 4'b0010;
        settle();
        chk("t6_first_grant", 32'(d1_ready), 32'b0010);
        step();
        valid = '0;
        settle();
        chk("t6_accept_op_b", d1_fb, 32'hDEADBEEF);
        chk("t6_accept_id", 32'(d1_id), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
